// File: rtl/decode_stage.sv
// decode_stage: decode/issue stage sitting directly behind fetch.
//
// Ports
//   clock, reset          rising-edge clock, asynchronous active-high reset
//   f_valid, f_pc, f_op,  fetch fields for the instruction presented this cycle
//   f_rs1, f_rs2, f_rd,
//   f_imm
//   d_ready               instruction accepted this cycle (fetch advances)
//   br_en, br_addr        taken-BEQ redirect; combinational, meaningful with d_ready
//   e_valid / e_ready     issue register handshake towards execute
//   e_op, e_rd, e_wen,    issued opcode, destination, write enable,
//   e_rs1_val, e_rs2_val, operand values and sign-extended immediate
//   e_imm
//   wb_en, wb_rd, wb_data writeback port into the register file
//
// Handshake: the issue register transfers to execute on a cycle where
// e_valid && e_ready. It may accept a new instruction in that same cycle,
// so back-to-back issue runs at one instruction per clock. e_valid never
// drops without a transfer or a reset.
module decode_stage #(
   parameter int XLEN = 32,
   parameter int NREG = 32
) (
   input  logic            clock,
   input  logic            reset,
   input  logic            f_valid,
   input  logic [XLEN-1:0] f_pc,
   input  logic [6:0]      f_op,
   input  logic [4:0]      f_rs1,
   input  logic [4:0]      f_rs2,
   input  logic [4:0]      f_rd,
   input  logic [11:0]     f_imm,
   output logic            d_ready,
   output logic            br_en,
   output logic [XLEN-1:0] br_addr,
   output logic            e_valid,
   input  logic            e_ready,
   output logic [6:0]      e_op,
   output logic [4:0]      e_rd,
   output logic            e_wen,
   output logic [XLEN-1:0] e_rs1_val,
   output logic [XLEN-1:0] e_rs2_val,
   output logic [XLEN-1:0] e_imm,
   input  logic            wb_en,
   input  logic [4:0]      wb_rd,
   input  logic [XLEN-1:0] wb_data
);

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_IMM    = 7'b0010011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;

   // architectural state
   logic [XLEN-1:0] rf_q [NREG];
   logic [XLEN-1:0] rf_d [NREG];
   logic [NREG-1:0] pend_q, pend_d;

   // issue register
   logic            e_valid_q, e_valid_d;
   logic [6:0]      e_op_q, e_op_d;
   logic [4:0]      e_rd_q, e_rd_d;
   logic            e_wen_q, e_wen_d;
   logic [XLEN-1:0] e_rs1_val_q, e_rs1_val_d;
   logic [XLEN-1:0] e_rs2_val_q, e_rs2_val_d;
   logic [XLEN-1:0] e_imm_q, e_imm_d;

   // decode results
   logic            use_rs1, use_rs2, wr_cls, is_br, wen_dec;
   logic [XLEN-1:0] imm_dec, br_off;
   logic [XLEN-1:0] rs1_val, rs2_val;
   logic            busy1, busy2, waw, full, stall, issue_load;

   always_comb begin
      use_rs1 = 1'b0;
      use_rs2 = 1'b0;
      wr_cls  = 1'b0;
      is_br   = 1'b0;
      imm_dec = '0;
      br_off  = '0;
      case (f_op)
         OPC_OP: begin
            use_rs1 = 1'b1;
            use_rs2 = 1'b1;
            wr_cls  = 1'b1;
         end
         OPC_IMM, OPC_LOAD: begin
            use_rs1 = 1'b1;
            wr_cls  = 1'b1;
            imm_dec = {{(XLEN-12){f_imm[11]}}, f_imm};
         end
         OPC_STORE: begin
            use_rs1 = 1'b1;
            use_rs2 = 1'b1;
            imm_dec = {{(XLEN-12){f_imm[11]}}, f_imm[11:5], f_rd};
         end
         OPC_BRANCH: begin
            use_rs1 = 1'b1;
            use_rs2 = 1'b1;
            is_br   = 1'b1;
            br_off  = {{(XLEN-13){f_imm[11]}}, f_imm[11], f_rd[0],
                       f_imm[10:5], f_rd[4:1], 1'b0};
         end
         default: ; // unknown opcodes issue as NOPs
      endcase
      // x0 is never a real destination
      wen_dec = wr_cls && (f_rd != 5'd0);
   end

   // Register read with same-cycle writeback bypass; x0 reads zero.
   always_comb begin
      rs1_val = (f_rs1 == 5'd0) ? '0 :
                (wb_en && wb_rd == f_rs1) ? wb_data : rf_q[f_rs1];
      rs2_val = (f_rs2 == 5'd0) ? '0 :
                (wb_en && wb_rd == f_rs2) ? wb_data : rf_q[f_rs2];
   end

   // Hazards. A pending register being written back this cycle is not a
   // hazard because the bypass supplies its value. pend_q[0] is never set.
   always_comb begin
      busy1      = use_rs1 && pend_q[f_rs1] && !(wb_en && wb_rd == f_rs1);
      busy2      = use_rs2 && pend_q[f_rs2] && !(wb_en && wb_rd == f_rs2);
      waw        = wen_dec && pend_q[f_rd] && !(wb_en && wb_rd == f_rd);
      // branches resolve here and need no issue slot
      full       = e_valid_q && !e_ready && !is_br;
      stall      = f_valid && (busy1 || busy2 || waw || full);
      d_ready    = f_valid && !stall;
      br_en      = d_ready && is_br && (rs1_val == rs2_val);
      br_addr    = f_pc + br_off;
      issue_load = d_ready && !is_br;
   end

   always_comb begin
      rf_d = rf_q;
      if (wb_en && wb_rd != 5'd0) rf_d[wb_rd] = wb_data;

      // clear before set so a same-cycle set on the same register wins
      pend_d = pend_q;
      if (wb_en) pend_d[wb_rd] = 1'b0;
      if (issue_load && wen_dec) pend_d[f_rd] = 1'b1;

      e_valid_d   = e_valid_q;
      e_op_d      = e_op_q;
      e_rd_d      = e_rd_q;
      e_wen_d     = e_wen_q;
      e_rs1_val_d = e_rs1_val_q;
      e_rs2_val_d = e_rs2_val_q;
      e_imm_d     = e_imm_q;
      if (issue_load) begin
         e_valid_d   = 1'b1;
         e_op_d      = f_op;
         e_rd_d      = f_rd;
         e_wen_d     = wen_dec;
         e_rs1_val_d = use_rs1 ? rs1_val : '0;
         e_rs2_val_d = use_rs2 ? rs2_val : '0;
         e_imm_d     = imm_dec;
      end else if (e_ready) begin
         e_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
         pend_q      <= '0;
         e_valid_q   <= 1'b0;
         e_op_q      <= '0;
         e_rd_q      <= '0;
         e_wen_q     <= 1'b0;
         e_rs1_val_q <= '0;
         e_rs2_val_q <= '0;
         e_imm_q     <= '0;
      end else begin
         for (int i = 0; i < NREG; i++) rf_q[i] <= rf_d[i];
         pend_q      <= pend_d;
         e_valid_q   <= e_valid_d;
         e_op_q      <= e_op_d;
         e_rd_q      <= e_rd_d;
         e_wen_q     <= e_wen_d;
         e_rs1_val_q <= e_rs1_val_d;
         e_rs2_val_q <= e_rs2_val_d;
         e_imm_q     <= e_imm_d;
      end
   end

   assign e_valid   = e_valid_q;
   assign e_op      = e_op_q;
   assign e_rd      = e_rd_q;
   assign e_wen     = e_wen_q;
   assign e_rs1_val = e_rs1_val_q;
   assign e_rs2_val = e_rs2_val_q;
   assign e_imm     = e_imm_q;

endmodule
